// File: rtl/wb_dbus_region_decoder_pkg.sv
`default_nettype none
// =============================================================================
// wb_dec_pkg : FSM state type and shared constants for wb_dbus_region_decoder
// Rev 1.0
// =============================================================================
package wb_dec_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam logic [31:0] RDT_ERR = 32'h0;
   localparam int          CNT_W   = 8;

endpackage
`default_nettype wire

// File: rtl/wb_dbus_region_decoder_timer.sv
`default_nettype none
// =============================================================================
// wb_dec_timer : BUSY-phase cycle counter with clear, enable and terminal count
// Rev 1.0
// =============================================================================
module wb_dec_timer
   import wb_dec_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] load,
   output logic             tc
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + ONE;
      end
   end

   // Terminal count fires during the load-th enabled cycle, so BUSY lasts exactly 'load' cycles.
   assign tc = en && !clr && ((cnt_q + ONE) == load);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_dbus_region_decoder.sv
`default_nettype none
// =============================================================================
// wb_dbus_region_decoder : SERV dbus to NREG-region Wishbone decoder with local/external acks
// Optional macro WB_DEC_TIMEOUT_EN adds an external-ack timeout.   Rev 1.0
// =============================================================================
module wb_dbus_region_decoder
   import wb_dec_pkg::*;
#(
   parameter int              NREG       = 4,
   parameter int              AW         = 32,
   parameter logic [NREG-1:0] LOCAL_MASK = {{(NREG-1){1'b0}}, 1'b1},
   parameter int              LOCAL_LAT  = 1,
   parameter int              TIMEOUT    = 255
)(
   input  logic               wb_clk,
   input  logic               wb_rst,
   input  logic [AW-1:0]      m_adr,
   input  logic               m_cyc,
   output logic [31:0]        m_rdt,
   output logic               m_ack,
   output logic               m_err,
   output logic [NREG-1:0]    s_cyc,
   input  logic [NREG*32-1:0] s_rdt,
   input  logic [NREG-1:0]    s_ack
);

   localparam int                RSEL_W = $clog2(NREG);
   localparam logic [RSEL_W:0]   NREG_L = (RSEL_W+1)'(NREG);
   localparam logic [CNT_W-1:0]  LAT_L  = CNT_W'(LOCAL_LAT);
   localparam logic [CNT_W-1:0]  TMO_L  = CNT_W'(TIMEOUT);
   localparam logic [NREG-1:0]   SEL0   = {{(NREG-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [RSEL_W-1:0] idx_q, idx_d;
   logic [NREG-1:0]   s_cyc_q, s_cyc_d;
   logic              m_ack_q, m_ack_d;
   logic              m_err_q, m_err_d;
   logic [31:0]       m_rdt_q, m_rdt_d;

   logic [31:0]       region_rdt [NREG];
   logic [RSEL_W-1:0] adr_idx;
   logic              adr_bad;
   logic              sel_local;
   logic              sel_ack;
   logic [31:0]       sel_rdt;
   logic              tmr_clr;
   logic              tmr_en;
   logic [CNT_W-1:0]  tmr_load;
   logic              tmr_tc;
   logic              unused_adr;

   for (genvar i = 0; i < NREG; i++) begin : g_region_rdt
      assign region_rdt[i] = s_rdt[32*i +: 32];
   end

   assign adr_idx    = m_adr[AW-1 -: RSEL_W];
   assign adr_bad    = ({1'b0, adr_idx} >= NREG_L);
   assign unused_adr = ^m_adr[AW-RSEL_W-1:0];

   assign sel_local  = LOCAL_MASK[idx_q];
   assign sel_ack    = s_ack[idx_q];
   assign sel_rdt    = region_rdt[idx_q];

   assign tmr_clr    = (state_q != BUSY);
   assign tmr_load   = sel_local ? LAT_L : TMO_L;
`ifdef WB_DEC_TIMEOUT_EN
   assign tmr_en     = (state_q == BUSY);
`else
   assign tmr_en     = (state_q == BUSY) && sel_local;
`endif

   wb_dec_timer u_timer (
      .clk  (wb_clk),
      .rst  (wb_rst),
      .clr  (tmr_clr),
      .en   (tmr_en),
      .load (tmr_load),
      .tc   (tmr_tc)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      s_cyc_d = '0;
      m_ack_d = 1'b0;
      m_err_d = 1'b0;
      m_rdt_d = m_rdt_q;
      unique case (state_q)
         IDLE: begin
            if (m_cyc) begin
               idx_d = adr_idx;
               if (adr_bad) begin
                  state_d = ACK;
                  m_ack_d = 1'b1;
                  m_err_d = 1'b1;
                  m_rdt_d = RDT_ERR;
               end else begin
                  state_d = BUSY;
                  s_cyc_d = SEL0 << adr_idx;
               end
            end
         end
         BUSY: begin
            // m_cyc is deliberately not looked at here: a started transfer always completes.
            s_cyc_d = s_cyc_q;
            if (sel_local ? tmr_tc : sel_ack) begin
               state_d = ACK;
               s_cyc_d = '0;
               m_ack_d = 1'b1;
               m_rdt_d = sel_rdt;
            end
`ifdef WB_DEC_TIMEOUT_EN
            else if (tmr_tc) begin
               state_d = ACK;
               s_cyc_d = '0;
               m_ack_d = 1'b1;
               m_err_d = 1'b1;
               m_rdt_d = RDT_ERR;
            end
`endif
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         s_cyc_q <= '0;
         m_ack_q <= 1'b0;
         m_err_q <= 1'b0;
         m_rdt_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         s_cyc_q <= s_cyc_d;
         m_ack_q <= m_ack_d;
         m_err_q <= m_err_d;
         m_rdt_q <= m_rdt_d;
      end
   end

   assign m_rdt = m_rdt_q;
   assign m_ack = m_ack_q;
   assign m_err = m_err_q;
   assign s_cyc = s_cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_dbus_region_decoder.sv
`default_nettype none
// =============================================================================
// tb_wb_dbus_region_decoder : directed vector bench for wb_dbus_region_decoder
// Rev 1.0
// =============================================================================
module tb_wb_dbus_region_decoder;

   localparam logic [31:0] R0 = 32'hCAFE_F00D;
   localparam logic [31:0] R1 = 32'h1111_1111;
   localparam logic [31:0] R2 = 32'h1234_5678;
   localparam logic [31:0] R3 = 32'hDEAD_BEEF;
   localparam logic [31:0] U1_R0 = 32'hA5A5_0001;

   logic          clk;
   logic          wb_rst;

   logic [31:0]   m_adr0;
   logic          m_cyc0;
   logic [31:0]   m_rdt0;
   logic          m_ack0;
   logic          m_err0;
   logic [3:0]    s_cyc0;
   logic [127:0]  s_rdt0;
   logic [3:0]    s_ack0;

   logic [31:0]   m_adr1;
   logic          m_cyc1;
   logic [31:0]   m_rdt1;
   logic          m_ack1;
   logic          m_err1;
   logic [2:0]    s_cyc1;
   logic [95:0]   s_rdt1;
   logic [2:0]    s_ack1;

   int n_pass;
   int n_chk;

   wb_dbus_region_decoder #(
      .NREG(4), .AW(32), .LOCAL_MASK(4'b0001), .LOCAL_LAT(1), .TIMEOUT(8)
   ) u0 (
      .wb_clk(clk), .wb_rst(wb_rst),
      .m_adr(m_adr0), .m_cyc(m_cyc0), .m_rdt(m_rdt0), .m_ack(m_ack0), .m_err(m_err0),
      .s_cyc(s_cyc0), .s_rdt(s_rdt0), .s_ack(s_ack0)
   );

   wb_dbus_region_decoder #(
      .NREG(3), .AW(32), .LOCAL_MASK(3'b011), .LOCAL_LAT(3), .TIMEOUT(8)
   ) u1 (
      .wb_clk(clk), .wb_rst(wb_rst),
      .m_adr(m_adr1), .m_cyc(m_cyc1), .m_rdt(m_rdt1), .m_ack(m_ack1), .m_err(m_err1),
      .s_cyc(s_cyc1), .s_rdt(s_rdt1), .s_ack(s_ack1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] adr;
      int          wrong_at;
      int          wrong_bit;
      int          ack_at;
      int          ack_bit;
      int          exp_cyc;
      logic [31:0] exp_rdt;
      logic        exp_err;
      logic [3:0]  exp_scyc;
      int          exp_busy;
   } vec_t;

   vec_t vecs[8];
   int   n_vec;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Cycle k is the k-th posedge after the one where m_cyc is raised; ack cycle = edge where master samples m_ack.
   task automatic run_vec(input vec_t v, output int ack_cyc, output logic [31:0] rdt, output logic err,
                          output logic [3:0] scyc_or, output int busy, output int nack, output int bad_oh);
      int stop_k;
      ack_cyc = 0; rdt = '0; err = 1'b0; scyc_or = '0; busy = 0; nack = 0; bad_oh = 0;
      stop_k = 40;
      @(posedge clk); #1;
      m_adr0 = v.adr;
      m_cyc0 = 1'b1;
      for (int k = 1; k <= stop_k; k++) begin
         @(posedge clk); #1;
         s_ack0 = '0;
         if (v.wrong_at == k) s_ack0[v.wrong_bit] = 1'b1;
         if (v.ack_at == k)   s_ack0[v.ack_bit]   = 1'b1;
         if (ack_cyc != 0 && k == ack_cyc) m_cyc0 = 1'b0;
         @(negedge clk);
         if (s_cyc0 != '0) begin
            busy++;
            scyc_or |= s_cyc0;
         end
         if (!$onehot0(s_cyc0)) bad_oh++;
         if (m_ack0) begin
            nack++;
            if (ack_cyc == 0) begin
               ack_cyc = k + 1;
               rdt     = m_rdt0;
               err     = m_err0;
               stop_k  = k + 4;
            end
         end
      end
      m_cyc0 = 1'b0;
      s_ack0 = '0;
   endtask

   task automatic run1(input logic [31:0] adr, output int ack_cyc, output logic [31:0] rdt,
                       output logic err, output logic [2:0] scyc_or, output int nack);
      int stop_k;
      ack_cyc = 0; rdt = '0; err = 1'b0; scyc_or = '0; nack = 0;
      stop_k = 30;
      @(posedge clk); #1;
      m_adr1 = adr;
      m_cyc1 = 1'b1;
      for (int k = 1; k <= stop_k; k++) begin
         @(posedge clk); #1;
         if (ack_cyc != 0 && k == ack_cyc) m_cyc1 = 1'b0;
         @(negedge clk);
         scyc_or |= s_cyc1;
         if (m_ack1) begin
            nack++;
            if (ack_cyc == 0) begin
               ack_cyc = k + 1;
               rdt     = m_rdt1;
               err     = m_err1;
               stop_k  = k + 4;
            end
         end
      end
      m_cyc1 = 1'b0;
   endtask

   int          r_cyc, r_busy, r_nack, r_bad;
   logic [31:0] r_rdt;
   logic        r_err;
   logic [3:0]  r_scyc;
   logic [2:0]  r_scyc1;
   int          b2b_cyc[3];
   int          b2b_n;

   initial begin
      n_pass = 0;
      n_chk  = 0;
      wb_rst = 1'b1;
      m_adr0 = '0; m_cyc0 = 1'b0; s_ack0 = '0; s_rdt0 = {R3, R2, R1, R0};
      m_adr1 = '0; m_cyc1 = 1'b0; s_ack1 = '0; s_rdt1 = {32'h0, 32'h2222_2222, U1_R0};

      //                adr           wat wbit ack abit cyc rdt  err scyc     busy
      vecs[0] = '{32'h0000_0010, 0, 0, 0, 0, 3, R0, 1'b0, 4'b0001, 1};
      vecs[1] = '{32'h8000_0004, 0, 0, 5, 2, 7, R2, 1'b0, 4'b0100, 5};
      vecs[2] = '{32'hC000_0000, 2, 1, 4, 3, 6, R3, 1'b0, 4'b1000, 4};
      vecs[3] = '{32'h4000_0000, 0, 0, 1, 1, 3, R1, 1'b0, 4'b0010, 1};
      vecs[4] = '{32'h3FFF_FFFC, 0, 0, 0, 0, 3, R0, 1'b0, 4'b0001, 1};
      vecs[5] = '{32'hC000_0008, 1, 0, 3, 3, 5, R3, 1'b0, 4'b1000, 3};
      n_vec = 6;
`ifdef WB_DEC_TIMEOUT_EN
      vecs[6] = '{32'h8000_0000, 0, 0, 0, 0, 10, 32'h0, 1'b1, 4'b0100, 8};
      vecs[7] = '{32'h8000_0000, 0, 0, 8, 2, 10, R2,    1'b0, 4'b0100, 8};
      n_vec = 8;
`endif

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ack0",  {31'b0, m_ack0}, 32'h0);
      chk("rst_err0",  {31'b0, m_err0}, 32'h0);
      chk("rst_rdt0",  m_rdt0, 32'h0);
      chk("rst_scyc0", {28'b0, s_cyc0}, 32'h0);
      chk("rst_scyc1", {29'b0, s_cyc1}, 32'h0);
      wb_rst = 1'b0;

      for (int i = 0; i < n_vec; i++) begin
         run_vec(vecs[i], r_cyc, r_rdt, r_err, r_scyc, r_busy, r_nack, r_bad);
         chk($sformatf("v%0d_ack_cycle", i), r_cyc, vecs[i].exp_cyc);
         chk($sformatf("v%0d_rdt", i), r_rdt, vecs[i].exp_rdt);
         chk($sformatf("v%0d_err", i), {31'b0, r_err}, {31'b0, vecs[i].exp_err});
         chk($sformatf("v%0d_scyc", i), {28'b0, r_scyc}, {28'b0, vecs[i].exp_scyc});
         chk($sformatf("v%0d_busy_cycles", i), r_busy, vecs[i].exp_busy);
         chk($sformatf("v%0d_ack_count", i), r_nack, 1);
         chk($sformatf("v%0d_onehot_viol", i), r_bad, 0);
      end

      // m_cyc held through two acks, then dropped mid-BUSY: three acks at cycles 3, 6, 9.
      b2b_cyc = '{0, 0, 0};
      b2b_n   = 0;
      @(posedge clk); #1;
      m_adr0 = 32'h0000_0020;
      m_cyc0 = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (k == 7) m_cyc0 = 1'b0;
         @(negedge clk);
         if (m_ack0) begin
            if (b2b_n < 3) b2b_cyc[b2b_n] = k + 1;
            b2b_n++;
         end
      end
      chk("b2b_count", b2b_n, 3);
      chk("b2b_ack1", b2b_cyc[0], 3);
      chk("b2b_ack2", b2b_cyc[1], 6);
      chk("b2b_ack3_after_drop", b2b_cyc[2], 9);
      @(posedge clk); #1;
      chk("rdt_hold", m_rdt0, R0);

      // Asynchronous reset in the middle of an external BUSY, m_cyc kept high.
      m_adr0 = 32'h8000_0000;
      m_cyc0 = 1'b1;
      s_ack0 = '0;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_scyc", {28'b0, s_cyc0}, 32'h4);
      #2 wb_rst = 1'b1;
      #1;
      chk("async_rst_scyc", {28'b0, s_cyc0}, 32'h0);
      chk("async_rst_rdt",  m_rdt0, 32'h0);
      chk("async_rst_ack",  {31'b0, m_ack0}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      wb_rst = 1'b0;
      @(posedge clk); #1;
      chk("restart_scyc", {28'b0, s_cyc0}, 32'h4);
      s_ack0 = 4'b0100;
      @(posedge clk); #1;
      s_ack0 = '0;
      chk("restart_ack", {31'b0, m_ack0}, 32'h1);
      chk("restart_rdt", m_rdt0, R2);
      @(posedge clk); #1;
      m_cyc0 = 1'b0;

      // Three-region instance: local read with latency 3, then an undecodable address.
      run1(32'h0000_0000, r_cyc, r_rdt, r_err, r_scyc1, r_nack);
      chk("u1_local_cycle", r_cyc, 5);
      chk("u1_local_rdt", r_rdt, U1_R0);
      chk("u1_local_err", {31'b0, r_err}, 32'h0);
      chk("u1_local_scyc", {29'b0, r_scyc1}, 32'h1);
      run1(32'hC000_0000, r_cyc, r_rdt, r_err, r_scyc1, r_nack);
      chk("u1_decerr_cycle", r_cyc, 2);
      chk("u1_decerr_rdt", r_rdt, 32'h0);
      chk("u1_decerr_err", {31'b0, r_err}, 32'h1);
      chk("u1_decerr_scyc", {29'b0, r_scyc1}, 32'h0);
      chk("u1_decerr_count", r_nack, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
